// File: rtl/aria_pkg.sv
// Shared ARIA output-path constants and block-to-word helpers.
// ARIA_OUT_BSWAP_EN enables the per-word byte-swap helper used by aria_blk_out.
package aria_pkg;

    localparam int unsigned ARIA_BLK_W  = 128;
    localparam int unsigned ARIA_WORD_W = 32;
    localparam int unsigned ARIA_NWORD  = 4;

    // Word k of a block; msw_first selects whether word 0 is bits [127:96] or [31:0].
    function automatic logic [ARIA_WORD_W-1:0] aria_word_sel(
        input logic [ARIA_BLK_W-1:0] blk,
        input logic [1:0]            k,
        input logic                  msw_first
    );
        logic [1:0] idx;
        idx = msw_first ? (2'd3 - k) : k;
        return blk[int'(idx)*ARIA_WORD_W +: ARIA_WORD_W];
    endfunction

`ifdef ARIA_OUT_BSWAP_EN
    function automatic logic [ARIA_BLK_W-1:0] aria_bswap_blk(input logic [ARIA_BLK_W-1:0] blk);
        logic [ARIA_BLK_W-1:0] res;
        res = '0;
        for (int w = 0; w < int'(ARIA_NWORD); w++) begin
            for (int b = 0; b < 4; b++) begin
                res[w*32 + b*8 +: 8] = blk[w*32 + (3-b)*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/aria_out_buf.sv
// Two-entry block buffer: ping-pong storage with write/read pointers and occupancy count.
// Caller guarantees push only when not full and pop only when not empty.
module aria_out_buf
    import aria_pkg::*;
#(
    parameter int unsigned WIDTH = ARIA_BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clr) begin
            // Contents are left as-is; only control state is flushed.
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/aria_blk_out.sv
// ARIA output stage: whitening-key XOR, two-block buffer, 4x32-bit valid/ready word stream.
// Optional ARIA_OUT_BSWAP_EN adds a bswap input that byte-reverses each word at capture.
module aria_blk_out
    import aria_pkg::*;
#(
    parameter int unsigned MSW_FIRST = 1,
    parameter int unsigned BUF_DEPTH = 2
) (
`ifdef ARIA_OUT_BSWAP_EN
    input  logic                   bswap,
`endif
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   blk_vld,
    output logic                   blk_rdy,
    input  logic [ARIA_BLK_W-1:0]  blk_din,
    input  logic [ARIA_BLK_W-1:0]  rk_din,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic [ARIA_WORD_W-1:0] dout,
    output logic                   dout_last,
    output logic                   busy
);

    if (BUF_DEPTH != 2) begin : g_depth_chk
        $error("aria_blk_out: only BUF_DEPTH = 2 is supported");
    end

    logic                  buf_full;
    logic                  buf_empty;
    logic [ARIA_BLK_W-1:0] buf_head;
    logic [ARIA_BLK_W-1:0] cap_blk;
    logic                  push;
    logic                  xfer;
    logic                  pop;
    logic [1:0]            wcnt_q;

    // Swapping at capture makes the flag effectively per-entry.
`ifdef ARIA_OUT_BSWAP_EN
    assign cap_blk = bswap ? aria_bswap_blk(blk_din ^ rk_din) : (blk_din ^ rk_din);
`else
    assign cap_blk = blk_din ^ rk_din;
`endif

    assign blk_rdy = ~buf_full;
    assign push    = blk_vld & blk_rdy;
    assign xfer    = dout_vld & dout_rdy;
    assign pop     = xfer & (wcnt_q == 2'd3);

    aria_out_buf #(
        .WIDTH (ARIA_BLK_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (cap_blk),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (buf_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= 2'd0;
        end else if (clr) begin
            wcnt_q <= 2'd0;
        end else if (xfer) begin
            wcnt_q <= wcnt_q + 2'd1;
        end
    end

    assign dout_vld  = ~buf_empty;
    assign busy      = dout_vld;
    assign dout_last = dout_vld & (wcnt_q == 2'd3);
    assign dout      = aria_word_sel(buf_head, wcnt_q, MSW_FIRST != 0);

endmodule

// File: tb/tb_aria_blk_out.sv
// Directed bench for aria_blk_out: MSW-first and LSW-first instances driven by shared stimulus.
module tb_aria_blk_out;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         blk_vld;
    logic         dout_rdy;
    logic [127:0] blk_din;
    logic [127:0] rk_din;
`ifdef ARIA_OUT_BSWAP_EN
    logic         bswap;
`endif

    logic        m_blk_rdy, m_vld, m_last, m_busy;
    logic [31:0] m_dout;
    logic        l_blk_rdy, l_vld, l_last, l_busy;
    logic [31:0] l_dout;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    aria_blk_out #(.MSW_FIRST(1), .BUF_DEPTH(2)) u_dut (
`ifdef ARIA_OUT_BSWAP_EN
        .bswap     (bswap),
`endif
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .blk_vld   (blk_vld),
        .blk_rdy   (m_blk_rdy),
        .blk_din   (blk_din),
        .rk_din    (rk_din),
        .dout_vld  (m_vld),
        .dout_rdy  (dout_rdy),
        .dout      (m_dout),
        .dout_last (m_last),
        .busy      (m_busy)
    );

    aria_blk_out #(.MSW_FIRST(0), .BUF_DEPTH(2)) u_dut_lsw (
`ifdef ARIA_OUT_BSWAP_EN
        .bswap     (bswap),
`endif
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .blk_vld   (blk_vld),
        .blk_rdy   (l_blk_rdy),
        .blk_din   (blk_din),
        .rk_din    (rk_din),
        .dout_vld  (l_vld),
        .dout_rdy  (dout_rdy),
        .dout      (l_dout),
        .dout_last (l_last),
        .busy      (l_busy)
    );

    typedef struct {
        logic       vld;
        logic [1:0] sel;
        logic       rdy;
        logic       exp_brdy;
        logic       exp_vld;
        logic [1:0] exp_blk;
        logic [1:0] exp_k;
    } vec_t;

    vec_t        vecs [23];
    logic [31:0] exp_w [3][4];

    function automatic vec_t mk(input logic vld, input logic [1:0] sel, input logic rdy,
                                input logic eb, input logic ev, input logic [1:0] blk,
                                input logic [1:0] k);
        vec_t v;
        v.vld = vld; v.sel = sel; v.rdy = rdy;
        v.exp_brdy = eb; v.exp_vld = ev; v.exp_blk = blk; v.exp_k = k;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Block A: spec vector; B: key 0; C: key all-ones.
    task automatic set_blk(input logic [1:0] sel);
        case (sel)
            2'd0: begin
                blk_din = 128'h00112233_44556677_8899AABB_CCDDEEFF;
                rk_din  = {4{32'h0F0F0F0F}};
            end
            2'd1: begin
                blk_din = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
                rk_din  = '0;
            end
            default: begin
                blk_din = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
                rk_din  = {128{1'b1}};
            end
        endcase
    endtask

    task automatic check_idle(input string tag);
        check({tag, " dout_vld"}, 32'(m_vld), 32'd0);
        check({tag, " busy"}, 32'(m_busy), 32'd0);
        check({tag, " blk_rdy"}, 32'(m_blk_rdy), 32'd1);
        check({tag, " lsw dout_vld"}, 32'(l_vld), 32'd0);
    endtask

    initial begin
        exp_w[0] = '{32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};
        exp_w[1] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
        exp_w[2] = '{32'h21524110, 32'h35010FF2, 32'hEDCBA987, 32'h6543210F};

        // Single block, then back-pressure/full, then push+pop in same cycle, then hold.
        vecs[0]  = mk(1, 0, 1, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 1, 0, 1);
        vecs[3]  = mk(0, 0, 1, 1, 1, 0, 2);
        vecs[4]  = mk(0, 0, 1, 1, 1, 0, 3);
        vecs[5]  = mk(0, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(1, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mk(1, 1, 0, 1, 1, 0, 0);
        vecs[8]  = mk(1, 2, 0, 0, 1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 1, 0, 0);
        vecs[10] = mk(0, 0, 1, 0, 1, 0, 1);
        vecs[11] = mk(0, 0, 1, 0, 1, 0, 2);
        vecs[12] = mk(0, 0, 1, 0, 1, 0, 3);
        vecs[13] = mk(0, 0, 1, 1, 1, 1, 0);
        vecs[14] = mk(0, 0, 1, 1, 1, 1, 1);
        vecs[15] = mk(0, 0, 1, 1, 1, 1, 2);
        vecs[16] = mk(1, 2, 1, 1, 1, 1, 3);
        vecs[17] = mk(0, 0, 1, 1, 1, 2, 0);
        vecs[18] = mk(0, 0, 1, 1, 1, 2, 1);
        vecs[19] = mk(0, 0, 0, 1, 1, 2, 2);
        vecs[20] = mk(0, 0, 1, 1, 1, 2, 2);
        vecs[21] = mk(0, 0, 1, 1, 1, 2, 3);
        vecs[22] = mk(0, 0, 0, 1, 0, 0, 0);

        rst = 1'b1; clr = 1'b0; blk_vld = 1'b0; dout_rdy = 1'b0;
        blk_din = '0; rk_din = '0;
`ifdef ARIA_OUT_BSWAP_EN
        bswap = 1'b0;
`endif
        #1;
        check_idle("reset");
        check("reset dout", m_dout, 32'd0);
        check("reset dout_last", 32'(m_last), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            check($sformatf("row%0d blk_rdy", i), 32'(m_blk_rdy), 32'(vecs[i].exp_brdy));
            check($sformatf("row%0d dout_vld", i), 32'(m_vld), 32'(vecs[i].exp_vld));
            check($sformatf("row%0d busy", i), 32'(m_busy), 32'(vecs[i].exp_vld));
            check($sformatf("row%0d dout_last", i), 32'(m_last),
                  32'(vecs[i].exp_vld && vecs[i].exp_k == 2'd3));
            if (vecs[i].exp_vld) begin
                check($sformatf("row%0d dout", i), m_dout,
                      exp_w[vecs[i].exp_blk][vecs[i].exp_k]);
                check($sformatf("row%0d lsw dout", i), l_dout,
                      exp_w[vecs[i].exp_blk][2'd3 - vecs[i].exp_k]);
            end
            blk_vld  = vecs[i].vld;
            set_blk(vecs[i].sel);
            dout_rdy = vecs[i].rdy;
        end

        // clr mid-block (wcnt=2) together with a push and a transfer.
        @(negedge clk);
        blk_vld = 1'b1; set_blk(2'd0); dout_rdy = 1'b0;
        @(negedge clk);
        blk_vld = 1'b0; dout_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre-clr dout", m_dout, exp_w[0][2]);
        clr = 1'b1; blk_vld = 1'b1; set_blk(2'd1);
        @(negedge clk);
        clr = 1'b0; blk_vld = 1'b0;
        check_idle("clr");
        @(negedge clk);
        check_idle("clr+1");
        blk_vld = 1'b1; set_blk(2'd2);
        @(negedge clk);
        blk_vld = 1'b0; dout_rdy = 1'b0;
        check("post-clr dout", m_dout, exp_w[2][0]);
        check("post-clr dout_last", 32'(m_last), 32'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // Async reset between edges with wcnt=1.
        blk_vld = 1'b1; set_blk(2'd1); dout_rdy = 1'b1;
        @(negedge clk);
        blk_vld = 1'b0;
        @(negedge clk);
        check("pre-rst dout", m_dout, exp_w[1][1]);
        dout_rdy = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle("async rst");
        check("async rst dout", m_dout, 32'd0);
        check("async rst lsw dout", l_dout, 32'd0);
        @(negedge clk);
        rst = 1'b0; dout_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post-rst%0d dout_vld", i), 32'(m_vld), 32'd0);
        end

`ifdef ARIA_OUT_BSWAP_EN
        blk_vld = 1'b1; set_blk(2'd0); bswap = 1'b1;
        @(negedge clk);
        blk_vld = 1'b0; bswap = 1'b0;
        check("bswap dout", m_dout, 32'h3C2D1E0F);
        check("bswap lsw dout", l_dout, 32'hF0E1D2C3);
        repeat (5) @(negedge clk);
        check_idle("bswap drain");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aria_blk_out.md
Name: aria_blk_out

Overview:
- Output end of the ARIA round datapath.
- Accepts the finished 128-bit round-layer result together with the final whitening round key, and XORs them into a ciphertext/plaintext block.
- Buffers up to two blocks and streams each out as four 32-bit words over a valid/ready interface toward the host/SPI side.
- Back-pressures the round core through blk_rdy, so the core can start the next block while the previous one drains.

Parameters:
- MSW_FIRST, 1: word order. 1 = bits [127:96] sent first; 0 = bits [31:0] sent first.
- BUF_DEPTH, 2: block buffer entries. Only 2 is supported; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- clr  input  1  synchronous clear: flushes buffer and word counter.
- blk_vld  input  1  finished block presented by the round core.
- blk_rdy  output  1  block buffer can accept a block.
- blk_din  input  128  round layer-2 result.
- rk_din  input  128  final round key, XORed with blk_din at capture.
- dout_vld  output  1  output word valid.
- dout_rdy  input  1  downstream accepts word.
- dout  output  32  output word.
- dout_last  output  1  current word is the 4th word of its block.
- busy  output  1  at least one block is buffered.

Behaviour:
- Reset (rst=1, async): buffer entries = 0, wr_ptr = rd_ptr = 0, count = 0, wcnt = 0. All outputs read 0 except blk_rdy = 1.
- Push:
  - Occurs when blk_vld & blk_rdy.
  - entry[wr_ptr] <= blk_din ^ rk_din; wr_ptr toggles.
  - Capture latency 1 clk: the earliest dout_vld is the cycle after the push.
- blk_rdy = (count != 2). Driven from registered count only, with no combinational path from dout_rdy. A full buffer refuses a push even when the last word drains in the same cycle.
- dout_vld = (count != 0); busy = dout_vld.
- dout = word wcnt of entry[rd_ptr]:
  - MSW_FIRST=1: word k = bits [127-32k : 96-32k].
  - MSW_FIRST=0: word k = bits [32k+31 : 32k].
- dout_last = dout_vld & (wcnt == 3).
- Word transfer:
  - Occurs when dout_vld & dout_rdy.
  - wcnt increments and wraps from 3 to 0.
  - When wcnt == 3 the block is popped: rd_ptr toggles.
- Simultaneous push and pop: count unchanged and both pointers advance.
- dout/dout_vld stay stable while dout_vld=1 and dout_rdy=0 (AXI-style hold).
- clr:
  - Has priority over push and pop in the same cycle.
  - Next cycle: count = 0, pointers = 0, wcnt = 0, dout_vld = 0.
  - Buffer contents need not be zeroed.
- Reset asserted mid-stream: partial block is discarded; no word is replayed after reset.
- dout is don't-care when dout_vld=0, but must be 0 after reset.
- Buffer control state: count in {0,1,2}. Word FSM is implicit in wcnt, SEND0..SEND3.

Optional Feature:
- ARIA_OUT_BSWAP_EN defined:
  - Adds input port bswap (1 bit).
  - When bswap=1 at push, each 32-bit word of the stored block is byte-reversed.
  - The flag is stored per entry, so later toggling does not affect buffered blocks.
- ARIA_OUT_BSWAP_EN undefined:
  - No bswap port.
  - Bytes are emitted in natural big-endian ARIA order.

Decomposition:
- Shared package aria_pkg holds:
  - ARIA_BLK_W = 128, ARIA_WORD_W = 32, ARIA_NWORD = 4.
  - Word-select function for block-to-word extraction.
- One natural sub-module, aria_out_buf: the 2-entry block buffer with pointers, count and push/pop.
- Word counter and muxing stay in the top.

Test Plan:
- Single block, XOR and order:
  - Stimulus: blk_din = 0x00112233_44556677_8899AABB_CCDDEEFF, rk_din = 0x0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F, dout_rdy=1, MSW_FIRST=1.
  - Response: words 0x0F1E2D3C, 0x4B5A6978, 0x8796A5B4, 0xC3D2E1F0 on 4 consecutive cycles starting 1 clk after push; dout_last on the 4th only.
- Back-pressure and full:
  - Stimulus: dout_rdy=0, push blocks A then B.
  - Response: blk_rdy=0 after the second push; a third blk_vld is not accepted; dout holds A word 0 stable.
  - Then release dout_rdy: A's 4 words, then B's 4 words; blk_rdy returns to 1 the cycle after A's last word transfers.
- Simultaneous push/pop:
  - Stimulus: count=1, push C in the same cycle as A's last-word transfer.
  - Response: count stays 1; the next dout is C word 0 with no bubble.
- clr priority:
  - Stimulus: clr=1 with blk_vld=1 and a transfer mid-block (wcnt=2).
  - Response: next cycle dout_vld=0, busy=0, blk_rdy=1; the pushed block is lost.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with wcnt=1.
  - Response: dout_vld, busy and dout go to 0 immediately, blk_rdy goes to 1; after release no stale word appears.
- MSW_FIRST=0 build, or ARIA_OUT_BSWAP_EN with bswap=1:
  - Stimulus: same input as the single-block test.
  - Response: MSW_FIRST=0 gives first word 0xC3D2E1F0; bswap=1 gives first word 0x3C2D1E0F.
